// File: rtl/args_serializer.sv
// args_serializer: sequencer in front of a registered argument mux.
//
// Accepts one packed vector of N W-bit arguments through in_valid/in_ready
// and holds it on mux_in. It then walks mux_sel over the active slots, one
// slot per issue cycle. The out_* qualifiers are registered on the issue
// edge, so they line up with the mux's one-cycle output.
//
// Ports:
//   clk, rst          clock (rising edge); asynchronous active-low reset
//   in_valid/ready    upstream vector handshake
//   in_data           packed arguments; slot k is in_data[k*W +: W]
//   in_cnt            active slot count; 0 or > N means N
//   mux_sel, mux_in   select and held vector driven to the mux
//   dn_ready          downstream accepts the mux output this cycle
//   out_valid         mux output carries a valid argument
//   out_idx           slot index of that argument
//   out_first/last    argument is slot 0 / last active slot of its vector
module args_serializer #(
  parameter int unsigned W = 10,
  parameter int unsigned N = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W*N-1:0]           in_data,
  input  logic [$clog2(N+1)-1:0]   in_cnt,
  output logic [$clog2(N)-1:0]     mux_sel,
  output logic [W*N-1:0]           mux_in,
  input  logic                     dn_ready,
  output logic                     out_valid,
  output logic [$clog2(N)-1:0]     out_idx,
  output logic                     out_first,
  output logic                     out_last
);

  localparam int unsigned CntW = $clog2(N + 1);
  localparam int unsigned SelW = $clog2(N);
  localparam logic [CntW-1:0] NumSlots = CntW'(N);
  localparam logic [SelW-1:0] LastSlot = SelW'(N - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [W*N-1:0]    args_q, args_d;
  logic [SelW-1:0]   cnt_q, cnt_d;
  logic [SelW-1:0]   sel_q, sel_d;
  logic              out_valid_q, out_valid_d;
  logic [SelW-1:0]   out_idx_q, out_idx_d;
  logic              out_first_q, out_first_d;
  logic              out_last_q, out_last_d;

  logic              issue;
  logic              sel_at_last;
  logic              accept;
  logic [CntW-1:0]   cnt_clamped;

  assign mux_in    = args_q;
  assign mux_sel   = sel_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;

  always_comb begin
    // An argument is issued whenever the mux output slot is free or being consumed.
    issue       = (state_q == StRun) && (!out_valid_q || dn_ready);
    sel_at_last = (sel_q == cnt_q);
    in_ready    = rst && ((state_q == StIdle) || (issue && sel_at_last));
    accept      = in_valid && in_ready;

    if ((in_cnt == '0) || (in_cnt > NumSlots)) begin
      cnt_clamped = NumSlots;
    end else begin
      cnt_clamped = in_cnt;
    end

    state_d     = state_q;
    args_d      = args_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;

    if (issue) begin
      out_valid_d = 1'b1;
      out_idx_d   = sel_q;
      out_first_d = (sel_q == '0);
      out_last_d  = sel_at_last;
      if (sel_q < cnt_q) begin
        sel_d = sel_q + SelW'(1);
      end else begin
        state_d = StIdle;
      end
    end else if (!out_valid_q || dn_ready) begin
      // Nothing new to present; flags keep stale values, qualified by out_valid.
      out_valid_d = 1'b0;
    end

    // Loading after the issue logic lets a back-to-back vector override the
    // return to idle on the same edge the last slot is sampled.
    if (accept) begin
      args_d  = in_data;
      cnt_d   = SelW'(cnt_clamped - CntW'(1));
      sel_d   = '0;
      state_d = StRun;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      args_q      <= '0;
      cnt_q       <= LastSlot;
      sel_q       <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      args_q      <= args_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_args_serializer.sv
// tb_args_serializer: directed and randomized bench for args_serializer.
// A registered mux stage is modelled here; expected arguments come from a
// queue filled with the slots of every accepted vector.
module tb_args_serializer;

  localparam int unsigned W  = 10;
  localparam int unsigned N  = 4;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned SW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W*N-1:0]  in_data;
  logic [CW-1:0]   in_cnt;
  logic [SW-1:0]   mux_sel;
  logic [W*N-1:0]  mux_in;
  logic            dn_ready;
  logic            out_valid;
  logic [SW-1:0]   out_idx;
  logic            out_first;
  logic            out_last;
  logic [W-1:0]    mux_out;

  typedef struct {
    logic [W-1:0] d;
    int           idx;
    bit           first;
    bit           last;
  } arg_t;

  arg_t         exp_q[$];
  logic [W-1:0] got_d[$];
  int           got_cyc[$];
  int           checks   = 0;
  int           failures = 0;
  int           cyc      = 0;

  args_serializer #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .mux_sel   (mux_sel),
    .mux_in    (mux_in),
    .dn_ready  (dn_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_first (out_first),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Mux stage: registers the selected slot, holding while the consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mux_out <= '0;
    else if (!(out_valid && !dn_ready)) mux_out <= mux_in[int'(mux_sel)*W +: W];
  end

  function automatic logic [W*N-1:0] vec4(input int a0, input int a1, input int a2,
                                          input int a3);
    return {W'(a3), W'(a2), W'(a1), W'(a0)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: sample at the falling edge, score consumed arguments, record
  // accepted vectors, then return just after the rising edge.
  task automatic cycle(output bit acc);
    bit   fire;
    arg_t e;
    int   n;
    @(negedge clk);
    fire = out_valid && dn_ready;
    acc  = in_valid && in_ready;
    if (fire) begin
      if (exp_q.size() == 0) begin
        chk("spurious_arg", 64'(exp_q.size() != 0), 64'(1));
      end else begin
        e = exp_q.pop_front();
        chk("arg_data", 64'(mux_out), 64'(e.d));
        chk("arg_idx", 64'(out_idx), 64'(e.idx));
        chk("arg_first", 64'(out_first), 64'(e.first));
        chk("arg_last", 64'(out_last), 64'(e.last));
        got_d.push_back(mux_out);
        got_cyc.push_back(cyc);
      end
    end
    if (acc) begin
      n = ((int'(in_cnt) == 0) || (int'(in_cnt) > N)) ? N : int'(in_cnt);
      for (int k = 0; k < n; k++) begin
        e.d     = in_data[k*W +: W];
        e.idx   = k;
        e.first = (k == 0);
        e.last  = (k == n - 1);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(input logic [W*N-1:0] d, input int c, input bit keep_valid);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_cnt   = CW'(c);
    for (int i = 0; i < 40 && !acc; i++) cycle(acc);
    chk("accept_timeout", 64'(acc), 64'(1));
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic drain();
    bit a;
    dn_ready = 1'b1;
    for (int i = 0; i < 60 && (exp_q.size() != 0 || out_valid); i++) cycle(a);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic chk_seq(input string tag, input int n, input int ev[8]);
    chk({tag, "_count"}, 64'(got_d.size()), 64'(n));
    for (int k = 0; k < n && k < got_d.size(); k++) chk(tag, 64'(got_d[k]), 64'(ev[k]));
    got_d.delete();
    got_cyc.delete();
  endtask

  initial begin
    bit a;
    int ev[8];

    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_cnt = '0; dn_ready = 1'b0;
    #1;
    // Reset state before any clock edge.
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_mux_sel", 64'(mux_sel), 64'(0));
    chk("rst_out_idx", 64'(out_idx), 64'(0));
    chk("rst_first_last", 64'({out_first, out_last}), 64'(0));
    chk("rst_mux_in", 64'(mux_in), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    #1 chk("idle_in_ready", 64'(in_ready), 64'(1));

    // Basic vector with exact latency and in_ready pattern.
    dn_ready = 1'b1; in_valid = 1'b1; in_data = vec4(10, 20, 30, 40); in_cnt = CW'(4);
    cycle(a);
    chk("basic_accept", 64'(a), 64'(1));
    in_valid = 1'b0;
    #1;
    chk("lat_no_out_yet", 64'(out_valid), 64'(0));
    chk("run_in_ready0", 64'(in_ready), 64'(0));
    cycle(a);
    chk("lat_first_valid", 64'(out_valid), 64'(1));
    chk("lat_first_data", 64'(mux_out), 64'(10));
    chk("run_in_ready1", 64'(in_ready), 64'(0));
    cycle(a);
    chk("run_in_ready2", 64'(in_ready), 64'(0));
    cycle(a);
    chk("last_issue_in_ready", 64'(in_ready), 64'(1));
    cycle(a);
    cycle(a);
    chk("gap_out_valid", 64'(out_valid), 64'(0));
    chk("gap_mux_sel_hold", 64'(mux_sel), 64'(3));
    chk("basic_consecutive", 64'(got_cyc[3] - got_cyc[0]), 64'(3));
    ev = '{10, 20, 30, 40, 0, 0, 0, 0};
    chk_seq("basic_seq", 4, ev);

    // Backpressure while slot 1 (20) is presented.
    send(vec4(10, 20, 30, 40), 4, 1'b0);
    for (int i = 0; i < 10 && !(out_valid && out_idx == 1); i++) cycle(a);
    dn_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(a);
      chk("bp_data", 64'(mux_out), 64'(20));
      chk("bp_valid", 64'(out_valid), 64'(1));
      chk("bp_mux_sel", 64'(mux_sel), 64'(2));
    end
    drain();
    ev = '{10, 20, 30, 40, 0, 0, 0, 0};
    chk_seq("bp_seq", 4, ev);

    // Back-to-back vectors with in_valid held.
    send(vec4(10, 20, 30, 40), 4, 1'b1);
    send(vec4(1, 2, 3, 4), 4, 1'b0);
    drain();
    chk("b2b_no_bubble", 64'(got_cyc[4] - got_cyc[3]), 64'(1));
    ev = '{10, 20, 30, 40, 1, 2, 3, 4};
    chk_seq("b2b_seq", 8, ev);

    // Short and clamped counts.
    ev = '{10, 20, 30, 40, 0, 0, 0, 0};
    send(vec4(10, 20, 30, 40), 2, 1'b0); drain(); chk_seq("cnt2_seq", 2, ev);
    send(vec4(10, 20, 30, 40), 1, 1'b0); drain(); chk_seq("cnt1_seq", 1, ev);
    send(vec4(10, 20, 30, 40), 0, 1'b0); drain(); chk_seq("cnt0_seq", 4, ev);
    send(vec4(10, 20, 30, 40), 7, 1'b0); drain(); chk_seq("cnt7_seq", 4, ev);

    // Reset asserted mid-vector, between clock edges.
    send(vec4(10, 20, 30, 40), 4, 1'b0);
    for (int i = 0; i < 10 && !(out_valid && out_idx == 1); i++) cycle(a);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_mux_sel", 64'(mux_sel), 64'(0));
    chk("mid_rst_out_idx", 64'(out_idx), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
    exp_q.delete();
    got_d.delete();
    got_cyc.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    #1 chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    send(vec4(1, 2, 3, 4), 4, 1'b0);
    drain();
    ev = '{1, 2, 3, 4, 0, 0, 0, 0};
    chk_seq("post_rst_seq", 4, ev);

    // Random vectors, counts, gaps and backpressure against the slot queue.
    for (int v = 0; v < 40; v++) begin
      bit acc = 1'b0;
      in_valid = 1'b1;
      in_data  = (W*N)'({$urandom, $urandom});
      in_cnt   = CW'($urandom_range(0, 7));
      for (int i = 0; i < 200 && !acc; i++) begin
        dn_ready = ($urandom_range(0, 3) != 0);
        cycle(acc);
      end
      chk("rand_accept", 64'(acc), 64'(1));
      in_valid = 1'b0;
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        dn_ready = ($urandom_range(0, 3) != 0);
        cycle(a);
      end
    end
    drain();
    got_d.delete();
    got_cyc.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
